// File: rtl/matrix_result_drain.sv
// Result drain for the systolic mesh: shifts accumulators out the east edge,
// buffers the N x N matrix, then streams it row-major over valid/ready.
module matrix_result_drain #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             mesh_done_i,
  input  logic [N-1:0][DATA_WIDTH-1:0]     east_i,
  output logic                             select_acc_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [DATA_WIDTH-1:0]            out_data_o,
  output logic [$clog2(N)-1:0]             out_row_o,
  output logic [$clog2(N)-1:0]             out_col_o,
  output logic                             out_last_o,
  output logic                             busy_o,
  output logic                             drain_done_o
);

  localparam int CW = $clog2(N);
  localparam int KW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STREAM
  } state_t;

  state_t                state;
  logic                  prev_done;
  logic [KW-1:0]         k;
  logic [DATA_WIDTH-1:0] buffer [N][N];

  logic          start;
  logic          xfer;
  logic [CW-1:0] cap_col;

  assign start   = mesh_done_i & ~prev_done;
  assign xfer    = out_valid_o & out_ready_i;
  assign cap_col = CW'(N - int'(k));

  assign out_data_o = out_valid_o ?
    buffer[out_row_o][out_col_o] : '0;

  // k-th shifted column arrives one cycle after its select cycle
  always_ff @(posedge clk_i) begin
    if (state == SHIFT && k != '0) begin
      for (int r = 0; r < N; r++) begin
        buffer[r][cap_col] <= east_i[r];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      prev_done    <= 1'b0;
      k            <= '0;
      select_acc_o <= 1'b0;
      out_valid_o  <= 1'b0;
      out_row_o    <= '0;
      out_col_o    <= '0;
      out_last_o   <= 1'b0;
      busy_o       <= 1'b0;
      drain_done_o <= 1'b0;
    end else begin
      prev_done    <= mesh_done_i;
      drain_done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= SHIFT;
            k            <= '0;
            select_acc_o <= 1'b1;
            busy_o       <= 1'b1;
          end
        end
        SHIFT: begin
          if (k == KW'(N)) begin
            state       <= STREAM;
            out_valid_o <= 1'b1;
            out_row_o   <= '0;
            out_col_o   <= '0;
            out_last_o  <= 1'b0;
          end else begin
            k            <= k + 1'b1;
            select_acc_o <= (int'(k) + 1 < N);
          end
        end
        STREAM: begin
          if (xfer) begin
            if (out_last_o) begin
              state        <= IDLE;
              out_valid_o  <= 1'b0;
              out_last_o   <= 1'b0;
              out_row_o    <= '0;
              out_col_o    <= '0;
              busy_o       <= 1'b0;
              drain_done_o <= 1'b1;
            end else begin
              if (out_col_o == CW'(N - 1)) begin
                out_col_o <= '0;
                out_row_o <= out_row_o + 1'b1;
              end else begin
                out_col_o <= out_col_o + 1'b1;
              end
              out_last_o <= (out_row_o == CW'(N - 1)) &&
                            (out_col_o == CW'(N - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_drain.sv
// Scoreboard bench for matrix_result_drain: N=4 and N=2 instances,
// behavioural mesh models feed east_i while select_acc_o is high.
module tb_matrix_result_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          r;
    int          c;
    bit          l;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];

  int total = 0;
  int bad   = 0;

  logic rst;
  logic md4, rdy4, sel4, v4, last4, busy4, done4;
  logic [31:0] d4;
  logic [1:0] row4, col4;
  logic [3:0][31:0] east4;

  logic md2, rdy2, sel2, v2, last2, busy2, done2;
  logic [31:0] d2;
  logic [0:0] row2, col2;
  logic [1:0][31:0] east2;

  logic [31:0] acc4 [4][4];
  logic [31:0] src4 [4][4];
  logic [31:0] acc2 [2][2];
  logic [31:0] src2 [2][2];
  bit ld4 = 0;
  bit ld2 = 0;

  int selc4 = 0, vcyc4 = 0, xfers4 = 0, dones4 = 0;
  int xfers2 = 0, dones2 = 0;

  matrix_result_drain #(.N(4), .DATA_WIDTH(32)) dut4 (
    .clk_i(clk), .rst_i(rst), .mesh_done_i(md4),
    .east_i(east4), .select_acc_o(sel4),
    .out_valid_o(v4), .out_ready_i(rdy4),
    .out_data_o(d4), .out_row_o(row4),
    .out_col_o(col4), .out_last_o(last4),
    .busy_o(busy4), .drain_done_o(done4)
  );

  matrix_result_drain #(.N(2), .DATA_WIDTH(32)) dut2 (
    .clk_i(clk), .rst_i(rst), .mesh_done_i(md2),
    .east_i(east2), .select_acc_o(sel2),
    .out_valid_o(v2), .out_ready_i(rdy2),
    .out_data_o(d2), .out_row_o(row2),
    .out_col_o(col2), .out_last_o(last2),
    .busy_o(busy2), .drain_done_o(done2)
  );

  // Mesh: each select cycle registers the east column and shifts east
  always @(posedge clk) begin
    if (ld4) begin
      acc4 <= src4;
    end else if (sel4) begin
      for (int r = 0; r < 4; r++) begin
        east4[r] <= acc4[r][3];
        for (int c = 0; c < 4; c++)
          acc4[r][c] <= (c == 0) ? 32'd0 : acc4[r][c-1];
      end
    end
  end

  always @(posedge clk) begin
    if (ld2) begin
      acc2 <= src2;
    end else if (sel2) begin
      for (int r = 0; r < 2; r++) begin
        east2[r] <= acc2[r][1];
        for (int c = 0; c < 2; c++)
          acc2[r][c] <= (c == 0) ? 32'd0 : acc2[r][c-1];
      end
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sel4) selc4++;
      if (done4) begin
        dones4++;
        check("busy_at_done4", 32'(busy4), 32'd0);
      end
      if (v4) begin
        vcyc4++;
        if (q4.size() == 0) begin
          check("unexpected4", 32'(v4), 32'd0);
        end else begin
          e = q4[0];
          check("data4", d4, e.d);
          check("tag4", 32'({row4, col4, last4}),
                32'({e.r[1:0], e.c[1:0], e.l}));
          if (rdy4) begin
            void'(q4.pop_front());
            xfers4++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done2) dones2++;
      if (v2) begin
        if (q2.size() == 0) begin
          check("unexpected2", 32'(v2), 32'd0);
        end else begin
          e = q2[0];
          check("data2", d2, e.d);
          check("tag2", 32'({row2, col2, last2}),
                32'({e.r[0], e.c[0], e.l}));
          if (rdy2) begin
            void'(q2.pop_front());
            xfers2++;
          end
        end
      end
    end
  end

  // mode: 0 ready high, 1 stall on (1,2), 2 random, 3 reset at transfer 7
  task automatic drain4(input int mode, input bit hold);
    int d0, x0;
    bit bp_done;
    bp_done = 0;
    d0 = dones4;
    x0 = xfers4;
    selc4 = 0;
    vcyc4 = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        q4.push_back('{src4[r][c], r, c, (r == 3 && c == 3)});
    @(posedge clk); #1 ld4 = 1; rdy4 = 1;
    @(posedge clk); #1 ld4 = 0; md4 = 1;
    @(posedge clk); #1 if (!hold) md4 = 0;
    for (int cyc = 0; cyc < 400 && dones4 == d0; cyc++) begin
      if (mode == 3 && xfers4 - x0 == 6) begin
        rst = 1;
        @(posedge clk); #1 rst = 0;
        check("rst_ctl", 32'({sel4, v4, last4, busy4, done4,
                              row4, col4}), 32'd0);
        check("rst_data", d4, 32'd0);
        q4.delete();
        repeat (3) @(posedge clk);
        #1 check("rst_no_done", 32'(dones4 - d0), 32'd0);
        check("rst_idle", 32'({busy4, v4}), 32'd0);
        return;
      end
      if (mode == 2) rdy4 = 1'($urandom_range(0, 1));
      if (mode == 1 && !bp_done && v4 &&
          row4 == 2'd1 && col4 == 2'd2) begin
        rdy4 = 0;
        repeat (3) begin @(posedge clk); #1; end
        rdy4 = 1;
        bp_done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    rdy4 = 1;
    if (dones4 == d0) check("timeout4", 32'd1, 32'd0);
    check("dones4", 32'(dones4 - d0), 32'd1);
    check("xfers4", 32'(xfers4 - x0), 32'd16);
    check("sel_cycles4", 32'(selc4), 32'd4);
    check("qempty4", 32'(q4.size()), 32'd0);
    if (mode == 0) check("consec4", 32'(vcyc4), 32'd16);
    if (mode == 1) check("stall_seen", 32'(bp_done), 32'd1);
  endtask

  initial begin
    int bz;
    rst = 1; md4 = 0; md2 = 0; rdy4 = 1; rdy2 = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("reset4_ctl", 32'({sel4, v4, last4, busy4, done4,
                             row4, col4}), 32'd0);
    check("reset4_data", d4, 32'd0);
    check("reset2_ctl", 32'({sel2, v2, last2, busy2, done2,
                             row2, col2}), 32'd0);

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        src4[r][c] = 32'(16 * r + c + 1);
    drain4(0, 0);
    drain4(1, 0);

    for (int n = 0; n < 10; n++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          src4[r][c] = $urandom;
      drain4(2, 0);
    end

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        src4[r][c] = 32'(100 + 4 * r + c);
    drain4(0, 1);
    bz = 0;
    repeat (20) begin @(posedge clk); #1 bz += int'(busy4); end
    check("hold_no_restart", 32'(bz), 32'd0);
    md4 = 0;
    @(posedge clk); #1;
    drain4(0, 0);

    drain4(3, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        src4[r][c] = 32'(16 * r + c + 1);
    drain4(0, 0);

    src2[0][0] = 32'hFFFF_FFFF; src2[0][1] = 32'h0;
    src2[1][0] = 32'h8000_0000; src2[1][1] = 32'h1;
    q2.push_back('{32'hFFFF_FFFF, 0, 0, 1'b0});
    q2.push_back('{32'h0000_0000, 0, 1, 1'b0});
    q2.push_back('{32'h8000_0000, 1, 0, 1'b0});
    q2.push_back('{32'h0000_0001, 1, 1, 1'b1});
    @(posedge clk); #1 ld2 = 1;
    @(posedge clk); #1 ld2 = 0; md2 = 1;
    @(posedge clk); #1 md2 = 0;
    for (int cyc = 0; cyc < 100 && dones2 == 0; cyc++)
      @(posedge clk);
    #1;
    if (dones2 == 0) check("timeout2", 32'd1, 32'd0);
    check("dones2", 32'(dones2), 32'd1);
    check("xfers2", 32'(xfers2), 32'd4);
    check("qempty2", 32'(q2.size()), 32'd0);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_result_drain.md
# matrix_result_drain

Output-side drain for the systolic mesh. After the mesh signals completion, it switches every PE into accumulator-shift mode and captures the N×N result matrix as it shifts out the east edge, one column per cycle. It then streams the results row-major over a valid/ready interface with row and column tags and a last flag. It is the reader counterpart to the north/west input queues that write operands into the mesh.

## Interface
- N, default 8: mesh dimension; must be ≥ 2.
- DATA_WIDTH, default 32: accumulator/result width.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- mesh_done_i  in  1  mesh completion; only its rising edge starts a drain.
- east_i  in  N×DATA_WIDTH  mesh east-edge outputs, one per row.
- select_acc_o  out  1  drives every PE's accumulator select: high means shift accumulators east.
- out_valid_o  out  1  result word available.
- out_ready_i  in  1  downstream accepts the word.
- out_data_o  out  DATA_WIDTH  result value.
- out_row_o  out  $clog2(N)  row index of out_data_o.
- out_col_o  out  $clog2(N)  column index of out_data_o.
- out_last_o  out  1  high with element (N-1, N-1).
- busy_o  out  1  high in any state except IDLE.
- drain_done_o  out  1  one-cycle pulse after the final transfer.

## Operation
- States: IDLE, SHIFT, STREAM.
- IDLE: outputs quiescent. A start occurs when mesh_done_i=1 and the registered previous mesh_done_i=0. On a start, go to SHIFT and clear the counter.
- SHIFT: counter k runs 0..N.
  - select_acc_o=1 while k<N.
  - Mesh contract: east_i[r] in the cycle after the k-th select cycle (k counted from 1) carries C[r][N-k].
  - For k≥1, capture east_i[r] into buffer[r][N-k] for every r.
  - At k=N, go to STREAM with index idx=0.
- STREAM: out_valid_o=1.
  - out_data_o=buffer[idx/N][idx%N], out_row_o=idx/N, out_col_o=idx%N.
  - out_last_o=1 when idx=N*N-1.
  - A transfer occurs on out_valid_o && out_ready_i; each transfer increments idx.
  - A transfer with out_last_o=1 pulses drain_done_o in the next cycle and returns to IDLE.
- Handshake: while out_valid_o=1 and out_ready_i=0, out_data_o, out_row_o, out_col_o and out_last_o stay stable. out_valid_o never drops before its transfer.
- mesh_done_i edges while busy_o=1 are ignored. The edge detector keeps updating, so a level held high across the return to IDLE does not restart the drain.
- Buffer: N×N×DATA_WIDTH registers, written only in SHIFT. Values are passed through unmodified; there is no arithmetic.
- Reset (including mid-drain): state=IDLE, counters=0, previous mesh_done=0. Buffer contents are don't-care. Any partial stream is abandoned without a last or done pulse.

## Timing
- Reset values: select_acc_o=0, out_valid_o=0, out_data_o=0, out_row_o=0, out_col_o=0, out_last_o=0, busy_o=0, drain_done_o=0.
- Rising edge of mesh_done_i sampled at edge T: busy_o=1 and select_acc_o=1 from T+1 through T+N.
- east_i captures occur at edges T+2 through T+N+1.
- out_valid_o rises at T+N+2.
- Minimum drain with out_ready_i held high: N*N transfers on consecutive cycles.
- drain_done_o is high for the single cycle after the last transfer. busy_o=0 in that same cycle.
- A start can be accepted in the cycle drain_done_o is high if mesh_done_i rises then.
- A rising edge of mesh_done_i coincident with the reset cycle is lost.

## Test plan
- N=4, DATA_WIDTH=32, out_ready_i=1. Mesh model with C[r][c]=16r+c+1; pulse mesh_done_i. Required: select_acc_o high for exactly 4 cycles; stream 1,2,3,4,17,…,52 on consecutive cycles with correct row/col tags; out_last_o only on 52; one drain_done_o pulse.
- Backpressure: drop out_ready_i for 3 cycles while element (1,2)=19 is presented. Required: data and tags stay stable, no skip or duplicate, total transfer count 16.
- Random out_ready_i (50%) over 10 drains with fresh random matrices. Required: every stream matches the scoreboard in row-major order.
- Hold mesh_done_i high through an entire drain and for 20 more cycles. Required: exactly one drain. Lower it, raise it again: required, a second drain.
- Assert rst_i at transfer 7. Required: all outputs at reset values the next cycle, no drain_done_o. A following mesh_done_i edge yields a complete, correct 16-word stream.
- N=2 corner case with C=[[0xFFFFFFFF,0],[0x80000000,1]]. Required: stream 0xFFFFFFFF,0,0x80000000,1 with out_last_o on the last word.
